// File: rtl/heart_rate_calc.sv
// rtl/heart_rate_calc.sv - peak strobe to beats-per-minute converter
//
// Purpose: synchronizes the asynchronous peak indicator, measures the
// beat-to-beat interval in milliseconds, rejects peaks inside the refractory
// window, averages the last four intervals and divides 60000 by that average
// with a 16-step restoring divider.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset
//   peak_in    asynchronous peak level from the peak detector
//   bpm        latest heart rate in BPM (truncated), held between strobes
//   bpm_valid  one-cycle strobe when bpm updates
//   no_signal  high while no valid rate is available
module heart_rate_calc #(
   parameter int TICKS_PER_MS    = 40000,
   parameter int MIN_INTERVAL_MS = 300,
   parameter int MAX_INTERVAL_MS = 2000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       peak_in,
   output logic [7:0] bpm,
   output logic       bpm_valid,
   output logic       no_signal
);

   typedef enum logic [1:0] {
      ACQUIRE,
      TRACK,
      AVG,
      DIVIDE
   } state_t;

   localparam int          PW       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PW-1:0] PRE_TC = PW'(TICKS_PER_MS - 1);
   localparam logic [15:0] MIN_MS   = 16'(MIN_INTERVAL_MS);
   localparam logic [15:0] MAX_MS   = 16'(MAX_INTERVAL_MS);
   localparam logic [15:0] DIVIDEND = 16'd60000;
   localparam logic [4:0]  DIV_STEPS = 5'd16;

   // synchronizer chain; edge_q is registered so the edge pulse is a clean flop output
   logic sync1_q, sync2_q, prev_q, edge_q;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   interval_q, interval_d;
   logic [15:0]   hist_q [4];
   logic [15:0]   hist_d [4];
   logic          first_q, first_d;
   logic [15:0]   avg_q, avg_d;
   logic [15:0]   rem_q, rem_d;
   logic [15:0]   quo_q, quo_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [7:0]    bpm_q, bpm_d;
   logic          bpm_valid_q, bpm_valid_d;
   logic          no_signal_q, no_signal_d;

   logic          tick;
   logic          accept;
   logic [17:0]   sum;
   logic [16:0]   rem_shift;
   logic [16:0]   diff;
   logic          unused_sum_bits;

   assign tick   = (presc_q == PRE_TC);
   // ACQUIRE takes any edge; TRACK only outside the refractory window; AVG/DIVIDE drop edges
   assign accept = edge_q && ((state_q == ACQUIRE) ||
                              ((state_q == TRACK) && (interval_q >= MIN_MS)));

   assign sum = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} +
                {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
   assign unused_sum_bits = ^sum[1:0];

   // restoring step: bring in the next dividend bit, trial-subtract; bit 16 is the borrow
   assign rem_shift = {rem_q, quo_q[15]};
   assign diff      = rem_shift - {1'b0, avg_q};

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      interval_d  = interval_q;
      for (int i = 0; i < 4; i++) hist_d[i] = hist_q[i];
      first_d     = first_q;
      avg_d       = avg_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      cnt_d       = cnt_q;
      bpm_d       = bpm_q;
      bpm_valid_d = 1'b0;
      no_signal_d = no_signal_q;

      if (accept) begin
         presc_d    = '0;
         interval_d = '0;
      end else begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (tick && (interval_q < MAX_MS)) interval_d = interval_q + 16'd1;
      end

      case (state_q)
         ACQUIRE: begin
            if (accept) begin
               first_d = 1'b1;
               state_d = TRACK;
            end
         end
         TRACK: begin
            // an accepted edge wins over a same-cycle timeout
            if (accept) begin
               if (first_q) begin
                  for (int i = 0; i < 4; i++) hist_d[i] = interval_q;
               end else begin
                  hist_d[0] = interval_q;
                  hist_d[1] = hist_q[0];
                  hist_d[2] = hist_q[1];
                  hist_d[3] = hist_q[2];
               end
               first_d = 1'b0;
               state_d = AVG;
            end else if (interval_d == MAX_MS) begin
               bpm_d       = '0;
               no_signal_d = 1'b1;
               state_d     = ACQUIRE;
            end
         end
         AVG: begin
            avg_d   = sum[17:2];
            rem_d   = '0;
            quo_d   = DIVIDEND;
            cnt_d   = '0;
            state_d = DIVIDE;
         end
         DIVIDE: begin
            if (cnt_q != DIV_STEPS) begin
               if (!diff[16]) begin
                  rem_d = diff[15:0];
                  quo_d = {quo_q[14:0], 1'b1};
               end else begin
                  rem_d = rem_shift[15:0];
                  quo_d = {quo_q[14:0], 1'b0};
               end
               cnt_d = cnt_q + 5'd1;
            end else begin
               bpm_d       = quo_q[7:0];
               bpm_valid_d = 1'b1;
               no_signal_d = 1'b0;
               state_d     = TRACK;
            end
         end
         default: state_d = ACQUIRE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         prev_q      <= 1'b0;
         edge_q      <= 1'b0;
         state_q     <= ACQUIRE;
         presc_q     <= '0;
         interval_q  <= '0;
         for (int i = 0; i < 4; i++) hist_q[i] <= '0;
         first_q     <= 1'b0;
         avg_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         bpm_q       <= '0;
         bpm_valid_q <= 1'b0;
         no_signal_q <= 1'b1;
      end else begin
         sync1_q     <= peak_in;
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         edge_q      <= sync2_q & ~prev_q;
         state_q     <= state_d;
         presc_q     <= presc_d;
         interval_q  <= interval_d;
         for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
         first_q     <= first_d;
         avg_q       <= avg_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         cnt_q       <= cnt_d;
         bpm_q       <= bpm_d;
         bpm_valid_q <= bpm_valid_d;
         no_signal_q <= no_signal_d;
      end
   end

   assign bpm       = bpm_q;
   assign bpm_valid = bpm_valid_q;
   assign no_signal = no_signal_q;

endmodule
